branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_if.sv | 31 +++
 rtl/branch_predict_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/branch_predict_if.sv
// Branch predictor bus: fetch-side prediction lookup, EX-side resolve
// inputs, resolved outcome and statistics.
//   master: drives fetch_pc, ex_valid, ex_inst, ex_pc, ex_pred, data_a, data_b
//   slave : drives pred_taken, br_taken, mispredict, branch_cnt, mispred_cnt
interface branch_predict_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_inst;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred;
    logic [XLEN-1:0]  data_a;
    logic [XLEN-1:0]  data_b;
    logic             br_taken;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output fetch_pc, ex_valid, ex_inst, ex_pc, ex_pred, data_a, data_b,
        input  pred_taken, br_taken, mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_inst, ex_pc, ex_pred, data_a, data_b,
        output pred_taken, br_taken, mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with EX-stage branch resolution.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bp       : branch_predict_if slave
//              fetch_pc -> pred_taken (combinational table read)
//              ex_* / data_a / data_b -> br_taken, mispredict (combinational)
//              branch_cnt, mispred_cnt: saturating statistics
// Contains bht_ctr, one 2-bit saturating counter per table entry.

module bht_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);
    logic [1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (upd_i) begin
            if (taken_i && ctr_q != 2'b11)       ctr_d = ctr_q + 2'b01;
            else if (!taken_i && ctr_q != 2'b00) ctr_d = ctr_q - 2'b01;
        end
    end

    // Reset lands on weakly-not-taken so a single taken flips the prediction.
    always_ff @(posedge clk) begin
        if (rst) ctr_q <= 2'b01;
        else     ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;
endmodule

module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_predict_if.slave  bp
);
    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [2:0]     funct3;
    logic           funct_ok, cond, is_br, br_taken;
    logic [IDX-1:0] fetch_idx, ex_idx;
    logic [BHT_ENTRIES-1:0][1:0] ctr;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

    assign funct3 = bp.ex_inst[14:12];

    always_comb begin
        funct_ok = 1'b1;
        cond     = 1'b0;
        case (funct3)
            3'b000:  cond = (bp.data_a == bp.data_b);
            3'b001:  cond = (bp.data_a != bp.data_b);
            3'b100:  cond = ($signed(bp.data_a) <  $signed(bp.data_b));
            3'b101:  cond = ($signed(bp.data_a) >= $signed(bp.data_b));
            3'b110:  cond = (bp.data_a <  bp.data_b);
            3'b111:  cond = (bp.data_a >= bp.data_b);
            default: funct_ok = 1'b0;
        endcase
    end

    assign is_br    = bp.ex_valid && (bp.ex_inst[6:0] == OP_BRANCH) && funct_ok;
    assign br_taken = is_br && cond;

    // Word-aligned PCs: bits [1:0] carry no information.
    assign fetch_idx = bp.fetch_pc[IDX+1:2];
    assign ex_idx    = bp.ex_pc[IDX+1:2];

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        bht_ctr u_ctr (
            .clk     (clk),
            .rst     (rst),
            .upd_i   (is_br && (ex_idx == IDX'(i))),
            .taken_i (br_taken),
            .ctr_o   (ctr[i])
        );
    end

    // Reads the registered counter, so a same-cycle update is not bypassed.
    assign bp.pred_taken = ctr[fetch_idx][1];

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (is_br && !(&branch_cnt_q))
            branch_cnt_d = branch_cnt_q + 1'b1;
        if (bp.mispredict && !(&mispred_cnt_q))
            mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp.br_taken    = br_taken;
    assign bp.mispredict  = is_br && (br_taken ^ bp.ex_pred);
    assign bp.branch_cnt  = branch_cnt_q;
    assign bp.mispred_cnt = mispred_cnt_q;

    // PC bits above the index and instruction fields outside opcode/funct3
    // are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bp.fetch_pc, bp.ex_pc, bp.ex_inst};
endmodule
